// File: rtl/delay_line_scheduler.sv
// ---------------------------------------------------------------------------
// delay_line_scheduler
//
// Purpose:
//   Time-multiplexes a single circular delay RAM across CHANNELS audio voices,
//   replacing per-voice shift-register delay lines in the echo/chorus path.
//   On every accepted sample_tick all channel inputs are latched. Each channel
//   then gets one read cycle and one write cycle. The read fetches the tap
//   written delay[ch] ticks earlier. The write stores the new sample. All
//   delayed samples are then presented together, along with a one-cycle
//   out_valid pulse.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   sample_tick  one-cycle strobe at the audio sample rate
//   in_data      channel c input sample at bits [c*WIDTH +: WIDTH]
//   cfg_we       write strobe for the shadow delay of channel cfg_ch
//   cfg_ch       channel selected by cfg_we
//   cfg_delay    tap delay in samples (0 is stored as 1)
//   out_data     delayed samples, same packing as in_data
//   out_valid    one-cycle pulse when out_data has been updated
//   busy         high while the sequencer is running a pass
//   overrun      sticky; a sample_tick arrived while busy
// ---------------------------------------------------------------------------
module delay_line_scheduler #(
    parameter int WIDTH    = 12,
    parameter int DEPTH    = 2048,
    parameter int CHANNELS = 4,
    parameter int AW       = $clog2(DEPTH),
    parameter int CW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_tick,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      cfg_we,
    input  logic [CW-1:0]             cfg_ch,
    input  logic [AW-1:0]             cfg_delay,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      overrun
);

    // Sequencer states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);
    localparam logic [AW-1:0] FILL_MAX = AW'(DEPTH - 1);

    // Architectural state
    logic [1:0]                       state_q,   state_d;
    logic [CW-1:0]                    ch_q,      ch_d;
    logic [AW-1:0]                    wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]                    fill_q,    fill_d;
    logic [CHANNELS*WIDTH-1:0]        hold_q,    hold_d;
    logic [CHANNELS*WIDTH-1:0]        out_q,     out_d;
    logic [CHANNELS-1:0][AW-1:0]      shadow_q,  shadow_d;
    logic [CHANNELS-1:0][AW-1:0]      delay_q,   delay_d;
    logic                             valid_q,   valid_d;
    logic                             overrun_q, overrun_d;

    // Shared RAM port
    logic [WIDTH-1:0]                 mem [DEPTH*CHANNELS];
    logic [CW+AW-1:0]                 mem_addr;
    logic                             mem_we;
    logic [WIDTH-1:0]                 mem_wdata;
    logic [WIDTH-1:0]                 rd_data_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        ch_d      = ch_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        hold_d    = hold_q;
        out_d     = out_q;
        shadow_d  = shadow_q;
        delay_d   = delay_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        mem_we    = 1'b0;
        // Tap address: the offset wraps naturally modulo DEPTH in AW bits.
        mem_addr  = {ch_q, wr_ptr_q - delay_q[ch_q]};
        mem_wdata = hold_q[int'(ch_q)*WIDTH +: WIDTH];

        // Shadow delays may change at any time; a delay of 0 is coerced to 1.
        if (cfg_we) begin
            shadow_d[cfg_ch] = (cfg_delay == '0) ? AW'(1) : cfg_delay;
        end

        // A tick that arrives mid-pass is dropped and flagged.
        if (sample_tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    hold_d  = in_data;
                    delay_d = shadow_q;   // freeze delays for the whole pass
                    ch_d    = '0;
                    state_d = S_RD;
                end
            end

            S_RD: begin
                // Read address is the default above; data returns next cycle.
                state_d = S_WR;
            end

            S_WR: begin
                // Until the buffer has seen delay[ch] writes, the tap
                // holds stale data from before reset, so emit silence.
                if (fill_q < delay_q[ch_q]) begin
                    out_d[int'(ch_q)*WIDTH +: WIDTH] = '0;
                end else begin
                    out_d[int'(ch_q)*WIDTH +: WIDTH] = rd_data_q;
                end
                mem_we   = 1'b1;
                mem_addr = {ch_q, wr_ptr_q};
                if (ch_q == LAST_CH) begin
                    valid_d = 1'b1;       // high during the DONE cycle
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_RD;
                end
            end

            S_DONE: begin
                wr_ptr_d = wr_ptr_q + 1'b1;   // DEPTH-1 wraps to 0
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            hold_q    <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= AW'(1);
                delay_q[c]  <= AW'(1);
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            hold_q    <= hold_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            shadow_q  <= shadow_d;
            delay_q   <= delay_d;
        end
    end

    // -----------------------------------------------------------------------
    // Single-port delay RAM, synchronous read with one cycle of latency
    // -----------------------------------------------------------------------
    // NOTE: the RAM has no reset so it maps onto block memory; stale contents
    // after reset are masked by the fill counter instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end else begin
            rd_data_q <= mem[mem_addr];
        end
    end

    assign out_data  = out_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_delay_line_scheduler.sv
// ---------------------------------------------------------------------------
// tb_delay_line_scheduler
//
// Purpose:
//   Directed self-checking bench for delay_line_scheduler with default
//   parameters (WIDTH=12, DEPTH=2048, CHANNELS=4). The bench computes every
//   expected value from the tick index and the delay that is in force.
// ---------------------------------------------------------------------------
module tb_delay_line_scheduler;

    localparam int WIDTH    = 12;
    localparam int DEPTH    = 2048;
    localparam int CHANNELS = 4;
    localparam int AW       = 11;
    localparam int CW       = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      sample_tick;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      cfg_we;
    logic [CW-1:0]             cfg_ch;
    logic [AW-1:0]             cfg_delay;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic                      out_valid;
    logic                      busy;
    logic                      overrun;

    int vectors     = 0;
    int miscompares = 0;

    delay_line_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .in_data     (in_data),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_delay   (cfg_delay),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [47:0] pack(input logic [11:0] c0, input logic [11:0] c1,
                                         input logic [11:0] c2, input logic [11:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    // Expected channel value for test 2: ramp base+k, delay d, fresh after reset.
    function automatic logic [11:0] ramp_exp(input int base, input int k, input int d);
        return (k <= d) ? 12'd0 : 12'(base + k - d);
    endfunction

    task automatic cfg(input int ch, input int d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_delay = AW'(d);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One full pass: tick at cycle T, expect out_valid at T+9 with exp_data.
    // Optionally issue a config write at T+2 while the pass is running.
    task automatic do_pass(input string tag, input logic [47:0] din, input logic [47:0] exp_data,
                           input bit mid_cfg, input int mid_ch, input int mid_d);
        int n;
        @(posedge clk); #1;
        sample_tick = 1'b1; in_data = din;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            if (mid_cfg && n == 2) begin
                cfg_we = 1'b1; cfg_ch = CW'(mid_ch); cfg_delay = AW'(mid_d);
            end else begin
                cfg_we = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        cfg_we = 1'b0;
        check({tag, "_lat"}, 64'(n), 64'd9);
        check({tag, "_data"}, 64'(out_data), 64'(exp_data));
    endtask

    initial begin
        logic [47:0] exp_w;
        reset = 1'b1; sample_tick = 1'b0; in_data = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_delay = '0;

        // ---- 1) reset state, ch0 ramp with default delay 1 ----
        #23;
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            do_pass($sformatf("t1_k%0d", k), pack(12'(k), 0, 0, 0), pack(12'(k - 1), 0, 0, 0), 0, 0, 0);
        end
        @(posedge clk); #1;
        check("t1_valid_pulse", 64'(out_valid), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);
        check("t1_hold", 64'(out_data), 64'(pack(12'd3, 0, 0, 0)));

        // ---- 2/3) ch2 delay 5, ch0 delay 1, ch1 written 7 then 0 (-> 1) ----
        do_reset();
        cfg(2, 5);
        cfg(0, 1);
        cfg(1, 7);
        cfg(1, 0);
        for (int k = 1; k <= 8; k++) begin
            exp_w = pack(ramp_exp(12'h000, k, 1), ramp_exp(12'h100, k, 1),
                         ramp_exp(12'h200, k, 5), ramp_exp(12'h300, k, 1));
            do_pass($sformatf("t2_k%0d", k),
                    pack(12'(k), 12'(12'h100 + k), 12'(12'h200 + k), 12'(12'h300 + k)),
                    exp_w, 0, 0, 0);
        end

        // ---- 4) maximum delay DEPTH-1 across two pointer wraps ----
        do_reset();
        cfg(0, DEPTH - 1);
        for (int k = 1; k <= 2 * DEPTH + 3; k++) begin
            exp_w = pack((k <= DEPTH - 1) ? 12'd0 : 12'((k - (DEPTH - 1)) * 3 + 1), 0, 0, 0);
            do_pass($sformatf("t4_k%0d", k), pack(12'(k * 3 + 1), 0, 0, 0), exp_w, 0, 0, 0);
        end

        // ---- 5) tick while busy is dropped and sets sticky overrun ----
        do_reset();
        @(posedge clk); #1;
        sample_tick = 1'b1; in_data = pack(12'h0A1, 0, 0, 0);
        @(posedge clk); #1;                      // T+1
        sample_tick = 1'b0;
        @(posedge clk); #1;                      // T+2
        @(posedge clk); #1;                      // T+3
        check("t5_no_overrun_yet", 64'(overrun), 64'd0);
        sample_tick = 1'b1; in_data = pack(12'h0B2, 0, 0, 0);
        @(posedge clk); #1;                      // T+4
        sample_tick = 1'b0;
        check("t5_overrun_set", 64'(overrun), 64'd1);
        for (int n = 4; n < 9; n++) begin
            @(posedge clk); #1;
        end
        check("t5_valid_t9", 64'(out_valid), 64'd1);
        check("t5_first_out", 64'(out_data), 64'd0);
        do_pass("t5_next", pack(12'h0C3, 0, 0, 0), pack(12'h0A1, 0, 0, 0), 0, 0, 0);
        check("t5_overrun_sticky", 64'(overrun), 64'd1);

        // ---- 7) config write mid-pass affects only the next pass ----
        do_pass("t7_old_delay", pack(12'h0D4, 0, 0, 0), pack(12'h0C3, 0, 0, 0), 1, 0, 2);
        do_pass("t7_new_delay", pack(12'h0E5, 0, 0, 0), pack(12'h0C3, 0, 0, 0), 0, 0, 0);

        // ---- 6) reset in WR of ch1 mid-pass ----
        @(posedge clk); #1;
        sample_tick = 1'b1; in_data = pack(12'h0F6, 0, 0, 0);
        @(posedge clk); #1;                      // T+1
        sample_tick = 1'b0;
        for (int n = 1; n < 4; n++) begin
            @(posedge clk); #1;                  // reach T+4 (WR of ch1)
        end
        check("t6_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_out_data", 64'(out_data), 64'd0);
        check("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_overrun", 64'(overrun), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_pass("t6_after_rst", pack(12'h011, 0, 0, 0), pack(0, 0, 0, 0), 0, 0, 0);
        do_pass("t6_second", pack(12'h022, 0, 0, 0), pack(12'h011, 0, 0, 0), 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
